sram_icb_arb: RTL and testbench

SRAM_ICB_ARB -- requirements
Module: sram_icb_arb

---
 rtl/sram_icb_arb_if.sv | 31 +++
 rtl/sram_icb_arb.sv | 130 +++++++++++++
 tb/tb_sram_icb_arb.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_icb_arb_if.sv
// ICB bus bundle: one command channel and one response channel.
// master modport: drives commands and rsp_ready; slave modport: drives
// cmd_ready and the response fields.
// Parameters: AW address width, DW data width (wmask is DW/8 bits).
interface sram_icb_arb_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic              icb_cmd_valid;
    logic              icb_cmd_ready;
    logic [AW-1:0]     icb_cmd_addr;
    logic              icb_cmd_read;
    logic [DW-1:0]     icb_cmd_wdata;
    logic [DW/8-1:0]   icb_cmd_wmask;
    logic              icb_rsp_valid;
    logic              icb_rsp_ready;
    logic              icb_rsp_err;
    logic [DW-1:0]     icb_rsp_rdata;

    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
        output icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
        input  icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
    );
endinterface

// File: rtl/sram_icb_arb.sv
// Two-master ICB arbiter in front of a single SRAM port, one transaction
// outstanding. Commands pass through combinationally in IDLE; read responses
// are routed combinationally to the owner; writes get a locally generated
// response (the SRAM only answers reads).
// Ports: clk, rst_n (async active-low), m0/m1 (slave side of each master's
//        ICB bus), sram (master side of the SRAM ICB bus).
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration; otherwise
//        fixed priority m0 over m1.
module sram_icb_arb #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    sram_icb_arb_if.slave  m0,
    sram_icb_arb_if.slave  m1,
    sram_icb_arb_if.master sram
);
    localparam int unsigned MW = DW / 8;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_RSP} state_t;

    state_t          state;
    logic            owner;
    logic            winner;
    logic            win_valid;
    logic [AW-1:0]   win_addr;
    logic            win_read;
    logic [DW-1:0]   win_wdata;
    logic [MW-1:0]   win_wmask;
    logic            owner_rsp_ready;
    logic            cmd_fire;

`ifdef SRAM_ARB_RR_EN
    logic            ptr;

    // Pointer breaks ties only; a lone requester always wins.
    always_comb begin
        winner = (m0.icb_cmd_valid && m1.icb_cmd_valid) ? ptr : m1.icb_cmd_valid;
    end
`else
    always_comb begin
        winner = !m0.icb_cmd_valid && m1.icb_cmd_valid;
    end
`endif

    // Winner's command fields
    always_comb begin
        win_valid = winner ? m1.icb_cmd_valid : m0.icb_cmd_valid;
        win_addr  = winner ? m1.icb_cmd_addr  : m0.icb_cmd_addr;
        win_read  = winner ? m1.icb_cmd_read  : m0.icb_cmd_read;
        win_wdata = winner ? m1.icb_cmd_wdata : m0.icb_cmd_wdata;
        win_wmask = winner ? m1.icb_cmd_wmask : m0.icb_cmd_wmask;
    end

    assign owner_rsp_ready = owner ? m1.icb_rsp_ready : m0.icb_rsp_ready;
    assign cmd_fire        = (state == IDLE) && win_valid && sram.icb_cmd_ready;

    // Command forwarding and response routing
    always_comb begin
        sram.icb_cmd_valid = 1'b0;
        sram.icb_cmd_addr  = win_addr;
        sram.icb_cmd_read  = win_read;
        sram.icb_cmd_wdata = win_wdata;
        sram.icb_cmd_wmask = win_wmask;
        sram.icb_rsp_ready = 1'b0;
        m0.icb_cmd_ready   = 1'b0;
        m1.icb_cmd_ready   = 1'b0;
        m0.icb_rsp_valid   = 1'b0;
        m0.icb_rsp_err     = 1'b0;
        m0.icb_rsp_rdata   = DW'(0);
        m1.icb_rsp_valid   = 1'b0;
        m1.icb_rsp_err     = 1'b0;
        m1.icb_rsp_rdata   = DW'(0);
        case (state)
            IDLE: begin
                sram.icb_cmd_valid = win_valid;
                m0.icb_cmd_ready   = !winner && sram.icb_cmd_ready;
                m1.icb_cmd_ready   = winner && sram.icb_cmd_ready;
            end
            RD_WAIT: begin
                sram.icb_rsp_ready = owner_rsp_ready;
                if (owner) begin
                    m1.icb_rsp_valid = sram.icb_rsp_valid;
                    m1.icb_rsp_err   = sram.icb_rsp_err;
                    m1.icb_rsp_rdata = sram.icb_rsp_rdata;
                end else begin
                    m0.icb_rsp_valid = sram.icb_rsp_valid;
                    m0.icb_rsp_err   = sram.icb_rsp_err;
                    m0.icb_rsp_rdata = sram.icb_rsp_rdata;
                end
            end
            WR_RSP: begin
                if (owner) m1.icb_rsp_valid = 1'b1;
                else       m0.icb_rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Transaction FSM, owner and arbitration pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            ptr   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        owner <= winner;
                        state <= win_read ? RD_WAIT : WR_RSP;
`ifdef SRAM_ARB_RR_EN
                        ptr   <= !winner;
`endif
                    end
                end
                RD_WAIT: begin
                    if (sram.icb_rsp_valid && owner_rsp_ready) state <= IDLE;
                end
                WR_RSP: begin
                    if (owner_rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_icb_arb.sv
// Directed bench for sram_icb_arb with a one-cycle-latency SRAM model.
module tb_sram_icb_arb;
    logic clk;
    logic rst_n;
    logic inj_rsp;
    int   total;
    int   bad;

    sram_icb_arb_if #(.AW(32), .DW(32)) m0_if ();
    sram_icb_arb_if #(.AW(32), .DW(32)) m1_if ();
    sram_icb_arb_if #(.AW(32), .DW(32)) sram_if ();

    sram_icb_arb #(.AW(32), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0_if),
        .m1    (m1_if),
        .sram  (sram_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: always ready, read data one cycle after the command,
    // response held until accepted.
    logic [31:0] mem [16];
    logic        rsp_pend;
    logic [31:0] rsp_data;

    assign sram_if.icb_cmd_ready = 1'b1;
    assign sram_if.icb_rsp_valid = rsp_pend | inj_rsp;
    assign sram_if.icb_rsp_err   = 1'b0;
    assign sram_if.icb_rsp_rdata = rsp_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_pend <= 1'b0;
            rsp_data <= 32'h0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h1234_5678;
            mem[8] <= 32'h1122_3344;
        end else begin
            if (rsp_pend && sram_if.icb_rsp_ready) rsp_pend <= 1'b0;
            if (sram_if.icb_cmd_valid && sram_if.icb_cmd_ready) begin
                if (sram_if.icb_cmd_read) begin
                    rsp_pend <= 1'b1;
                    rsp_data <= mem[sram_if.icb_cmd_addr[5:2]];
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (sram_if.icb_cmd_wmask[b])
                            mem[sram_if.icb_cmd_addr[5:2]][8*b +: 8] <= sram_if.icb_cmd_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_m0(input logic v, input logic rd, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] wm);
        m0_if.icb_cmd_valid = v;
        m0_if.icb_cmd_read  = rd;
        m0_if.icb_cmd_addr  = a;
        m0_if.icb_cmd_wdata = wd;
        m0_if.icb_cmd_wmask = wm;
    endtask

    task automatic set_m1(input logic v, input logic rd, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] wm);
        m1_if.icb_cmd_valid = v;
        m1_if.icb_cmd_read  = rd;
        m1_if.icb_cmd_addr  = a;
        m1_if.icb_cmd_wdata = wd;
        m1_if.icb_cmd_wmask = wm;
    endtask

    initial begin
        logic w;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        inj_rsp = 1'b0;
        set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        m0_if.icb_rsp_ready = 1'b1;
        m1_if.icb_rsp_ready = 1'b1;

        // Reset state
        @(negedge clk); #1;
        chk("rst_m0_rsp_valid", m0_if.icb_rsp_valid, 1'b0);
        chk("rst_m1_rsp_valid", m1_if.icb_rsp_valid, 1'b0);
        chk("rst_sram_cmd_valid", sram_if.icb_cmd_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // m0 read of 0x10
        @(negedge clk);
        set_m0(1'b1, 1'b1, 32'h10, 32'h0, 4'h0);
        #1;
        chk("rd_sram_cmd_valid", sram_if.icb_cmd_valid, 1'b1);
        chk("rd_sram_cmd_addr", sram_if.icb_cmd_addr, 32'h10);
        chk("rd_sram_cmd_read", sram_if.icb_cmd_read, 1'b1);
        chk("rd_m0_cmd_ready", m0_if.icb_cmd_ready, 1'b1);
        chk("rd_m1_cmd_ready", m1_if.icb_cmd_ready, 1'b0);
        @(negedge clk);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        chk("rd_m0_rsp_valid", m0_if.icb_rsp_valid, 1'b1);
        chk("rd_m0_rsp_rdata", m0_if.icb_rsp_rdata, 32'h1234_5678);
        chk("rd_m0_rsp_err", m0_if.icb_rsp_err, 1'b0);
        chk("rd_m1_rsp_valid", m1_if.icb_rsp_valid, 1'b0);
        chk("rd_sram_cmd_valid_busy", sram_if.icb_cmd_valid, 1'b0);
        @(negedge clk); #1;
        chk("rd_m0_rsp_done", m0_if.icb_rsp_valid, 1'b0);

        // m1 masked write to 0x20
        set_m1(1'b1, 1'b0, 32'h20, 32'hDEAD_BEEF, 4'b0011);
        #1;
        chk("wr_sram_cmd_valid", sram_if.icb_cmd_valid, 1'b1);
        chk("wr_sram_cmd_read", sram_if.icb_cmd_read, 1'b0);
        chk("wr_sram_cmd_wdata", sram_if.icb_cmd_wdata, 32'hDEAD_BEEF);
        chk("wr_sram_cmd_wmask", sram_if.icb_cmd_wmask, 4'b0011);
        chk("wr_m1_cmd_ready", m1_if.icb_cmd_ready, 1'b1);
        chk("wr_m0_cmd_ready", m0_if.icb_cmd_ready, 1'b0);
        @(negedge clk);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        chk("wr_m1_rsp_valid", m1_if.icb_rsp_valid, 1'b1);
        chk("wr_m1_rsp_err", m1_if.icb_rsp_err, 1'b0);
        chk("wr_m1_rsp_rdata", m1_if.icb_rsp_rdata, 32'h0);
        chk("wr_m0_rsp_valid", m0_if.icb_rsp_valid, 1'b0);
        chk("wr_sram_cmd_valid_busy", sram_if.icb_cmd_valid, 1'b0);
        chk("wr_sram_rsp_ready", sram_if.icb_rsp_ready, 1'b0);

        // Readback of 0x20 through m0
        @(negedge clk);
        set_m0(1'b1, 1'b1, 32'h20, 32'h0, 4'h0);
        @(negedge clk);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        chk("rb_m0_rsp_valid", m0_if.icb_rsp_valid, 1'b1);
        chk("rb_m0_rsp_rdata", m0_if.icb_rsp_rdata, 32'h1122_BEEF);

        // Owner backpressure for 5 cycles while m1 requests
        @(negedge clk);
        m0_if.icb_rsp_ready = 1'b0;
        set_m0(1'b1, 1'b1, 32'h10, 32'h0, 4'h0);
        @(negedge clk);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m1(1'b1, 1'b1, 32'h20, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_m0_rsp_valid", m0_if.icb_rsp_valid, 1'b1);
            chk("bp_m0_rsp_rdata", m0_if.icb_rsp_rdata, 32'h1234_5678);
            chk("bp_m0_cmd_ready", m0_if.icb_cmd_ready, 1'b0);
            chk("bp_m1_cmd_ready", m1_if.icb_cmd_ready, 1'b0);
            chk("bp_sram_cmd_valid", sram_if.icb_cmd_valid, 1'b0);
            chk("bp_m1_rsp_valid", m1_if.icb_rsp_valid, 1'b0);
            @(negedge clk);
        end
        m0_if.icb_rsp_ready = 1'b1;
        #1;
        chk("bp_release_rdata", m0_if.icb_rsp_rdata, 32'h1234_5678);
        @(negedge clk); #1;
        chk("bp_m1_granted", m1_if.icb_cmd_ready, 1'b1);
        chk("bp_m0_not_granted", m0_if.icb_cmd_ready, 1'b0);
        @(negedge clk);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        chk("bp_m1_rsp_valid", m1_if.icb_rsp_valid, 1'b1);
        chk("bp_m1_rsp_rdata", m1_if.icb_rsp_rdata, 32'h1122_BEEF);
        chk("bp_m0_rsp_quiet", m0_if.icb_rsp_valid, 1'b0);

        // Both masters continuously reading
        @(negedge clk);
        set_m0(1'b1, 1'b1, 32'h10, 32'h0, 4'h0);
        set_m1(1'b1, 1'b1, 32'h20, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
`ifdef SRAM_ARB_RR_EN
            w = (k % 2) != 0;
`else
            w = 1'b0;
`endif
            #1;
            chk("arb_m0_cmd_ready", m0_if.icb_cmd_ready, !w);
            chk("arb_m1_cmd_ready", m1_if.icb_cmd_ready, w);
            @(negedge clk); #1;
            chk("arb_m0_rsp_valid", m0_if.icb_rsp_valid, !w);
            chk("arb_m1_rsp_valid", m1_if.icb_rsp_valid, w);
            if (w) chk("arb_m1_rdata", m1_if.icb_rsp_rdata, 32'h1122_BEEF);
            else   chk("arb_m0_rdata", m0_if.icb_rsp_rdata, 32'h1234_5678);
            @(negedge clk);
        end
        set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Reset pulse during RD_WAIT
        @(negedge clk);
        m0_if.icb_rsp_ready = 1'b0;
        set_m0(1'b1, 1'b1, 32'h10, 32'h0, 4'h0);
        @(negedge clk);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        chk("rr_m0_rsp_before", m0_if.icb_rsp_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rr_m0_rsp_in_reset", m0_if.icb_rsp_valid, 1'b0);
        chk("rr_m1_rsp_in_reset", m1_if.icb_rsp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        m0_if.icb_rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("rr_m0_rsp_after", m0_if.icb_rsp_valid, 1'b0);
        chk("rr_m1_rsp_after", m1_if.icb_rsp_valid, 1'b0);
        chk("rr_sram_rsp_ready_idle", sram_if.icb_rsp_ready, 1'b0);

        // Stray SRAM response in IDLE is ignored
        inj_rsp = 1'b1;
        #1;
        chk("stray_m0_rsp_valid", m0_if.icb_rsp_valid, 1'b0);
        chk("stray_m1_rsp_valid", m1_if.icb_rsp_valid, 1'b0);
        chk("stray_sram_rsp_ready", sram_if.icb_rsp_ready, 1'b0);
        @(negedge clk);
        inj_rsp = 1'b0;

        // Normal read after reset
        set_m0(1'b1, 1'b1, 32'h10, 32'h0, 4'h0);
        #1;
        chk("post_m0_cmd_ready", m0_if.icb_cmd_ready, 1'b1);
        @(negedge clk);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        chk("post_m0_rsp_valid", m0_if.icb_rsp_valid, 1'b1);
        chk("post_m0_rsp_rdata", m0_if.icb_rsp_rdata, 32'h1234_5678);
        @(negedge clk); #1;
        chk("post_m0_rsp_done", m0_if.icb_rsp_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
